// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the timer_dev countdown timer
package timer_pkg;

  // Counting FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  // Register word offsets, decoded from addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // MODE field values; 2'b1x falls back to one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Expand per-byte enables into a 32-bit bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with irq; TIMER_BYTE_WRITE_EN enables byte-lane writes
module timer_dev
  import timer_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic [1:0]  off;
  logic        wr_ok;
  logic [31:0] wmask;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [3:0]  ctrl_w;
  logic        unused_addr;

  // Only addr[3:2] selects a register; low byte-offset bits are don't-care
  assign unused_addr = ^addr;

  // Decode bus writes and form the software-written CTRL value
  always_comb begin
    off = addr[3:2];
`ifdef TIMER_BYTE_WRITE_EN
    wr_ok = we & (|byteen);
    wmask = lane_mask(byteen);
`else
    wr_ok = we & (byteen == 4'b1111);
    wmask = '1;
`endif
    ctrl_wr   = wr_ok && (off == OFF_CTRL);
    preset_wr = wr_ok && (off == OFF_PRESET);
    ctrl_w    = ctrl_wr ? ((ctrl_q & ~wmask[3:0]) | (wdata[3:0] & wmask[3:0])) : ctrl_q;
  end

  // Next-state logic; LOAD/CNT see the freshly written EN so a disable takes effect at once
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_w;
    preset_d   = preset_wr ? ((preset_q & ~wmask) | (wdata & wmask)) : preset_q;
    count_d    = count_q;
    irq_flag_d = ctrl_wr ? 1'b0 : irq_flag_q;
    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = LOAD;
      end
      LOAD: begin
        if (!ctrl_w[CTRL_EN]) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!ctrl_w[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else if (!ctrl_wr) begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = ctrl_d[CTRL_IM] & irq_flag_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  // Combinational register readback
  always_comb begin
    case (off)
      OFF_CTRL:   rdata = {28'd0, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU data port, downstream of the M stage.
- Consumes the same address, write data, byte enables and write strobe that the pipeline drives to data memory.
- Returns read data to the M-stage load path and raises an interrupt request line for the future CP0/exception stage.
- Three 32-bit registers; 4-state counting FSM.

Parameters:
- ADDR_W, 4, number of low address bits decoded; registers at word offsets 0/4/8.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  ADDR_W  byte address within timer window; only bits [3:2] used
- we  input  1  write strobe from the bridge (address already decoded to this device)
- byteen  input  4  byte enables, same encoding as m_data_byteen
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr
- irq  output  1  interrupt request, registered

Behaviour:
- Reset: ctrl, preset, count = 0; state = IDLE; irq_flag = 0; irq = 0. rdata follows addr combinationally.
- Register map (addr[3:2]):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0, writes ignored.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3 reads 0.
- Write acceptance: we=1 and byteen==4'b1111 (see Optional Feature). Registers update at the clock edge.
- MODE: 2'b00 one-shot, 2'b01 auto-reload; 2'b1x behaves as 2'b00.
- FSM, evaluated each edge (not in reset):
  - IDLE: if ctrl.EN → LOAD.
  - LOAD: count <= preset; → CNT.
  - CNT: if !ctrl.EN → IDLE, count held. Else if count > 1: count <= count-1. Else: count <= 0, irq_flag <= 1, → INT.
  - INT, mode one-shot: ctrl.EN <= 0; → IDLE; irq_flag stays 1.
  - INT, mode auto-reload: → IDLE (EN still set, so LOAD follows); irq_flag <= 0.
- irq_flag clearing:
  - One-shot: cleared only by an accepted CTRL write.
  - Auto-reload: irq_flag is high only for the single cycle the FSM is in INT.
- irq = ctrl.IM & irq_flag, registered. IM=0 masks the output but does not clear the flag.
- Latency: CTRL write with EN=1 at edge E0 → LOAD after E1 → count=preset after E2 → preset N≥1 reaches 0 and irq=1 after edge E(N+2).
- Boundary conditions:
  - PRESET=0 or 1: the first CNT edge goes straight to INT.
  - Count never wraps below 0.
- Simultaneous events:
  - A CTRL write in the same cycle as the FSM's own EN clear in INT: the software write wins.
  - A PRESET write during CNT does not touch count; it takes effect at the next LOAD.
  - A CTRL write with EN=0 during CNT or LOAD: state → IDLE the next edge.
- Reset mid-count: all state returns to reset values at that edge; irq drops on the same edge.

Optional Feature:
- Macro: TIMER_BYTE_WRITE_EN.
- Defined: any nonzero byteen writes CTRL/PRESET. Each enabled byte lane updates only its own byte; CTRL bits outside [3:0] are still ignored.
- Not defined: only full-word writes (byteen==4'b1111) are accepted; partial writes are dropped silently with no state change.

Decomposition:
- Package timer_pkg holds:
  - FSM state encodings (IDLE, LOAD, CNT, INT, 2-bit);
  - register word offsets (CTRL=0, PRESET=1, COUNT=2);
  - MODE constants (ONESHOT=2'b00, RELOAD=2'b01);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3).
- Single module; no sub-module is natural at this size.

Test Plan:
- Reset, then read offsets 0/4/8/C → all 0; irq=0.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM) at E0 → COUNT reads 5,4,3,2,1,0 on successive cycles; irq=1 after E7; CTRL reads 0x8; irq stays 1 until CTRL write 0x8 → irq=0 next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) → irq pulses 1 cycle every 6 cycles; COUNT reloads to 3 each period.
- During CNT with count=4, write CTRL=0x8 → IDLE next edge, COUNT holds 4, no irq; rewrite 0x9 → reloads from PRESET.
- PRESET=0, CTRL=0x9 → irq=1 three edges after the write. Write byteen=4'b0011 to PRESET: ignored without TIMER_BYTE_WRITE_EN; updates only the low half with it.
- Assert reset while count=10 → next cycle COUNT=0, state IDLE, irq=0.
